// File: rtl/wave_pkg.sv
// Shared definitions for the multi-mode waveform shaper: mode encodings and
// fixed-point reference levels.
package wave_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SQUARE = 2'd0;
    localparam mode_t MODE_PULSE  = 2'd1;
    localparam mode_t MODE_SAW    = 2'd2;
    localparam mode_t MODE_TRI    = 2'd3;

    function automatic int one_f(input int frac_w);
        return 1 << frac_w;
    endfunction

    function automatic int half_f(input int phase_w);
        return 1 << (phase_w - 1);
    endfunction

endpackage

// File: rtl/wave_shape_unit.sv
// Combinational phase -> unscaled sample u, signed Q2.FRAC_W, full scale +/-ONE.
module wave_shape_unit
    import wave_pkg::*;
#(
    parameter int PHASE_W = 12,
    parameter int FRAC_W  = 16
) (
    input  logic [PHASE_W-1:0]        phase_i,
    input  mode_t                     mode_i,
    input  logic [PHASE_W-1:0]        duty_i,
    output logic signed [FRAC_W+1:0]  u_o
);

    localparam int U_W    = FRAC_W + 2;
    localparam int SAW_SH = FRAC_W + 1 - PHASE_W;
    localparam int TRI_SH = FRAC_W + 2 - PHASE_W;
    localparam logic signed [U_W-1:0] ONE  = U_W'(one_f(FRAC_W));
    localparam logic [PHASE_W-1:0]    HALF = PHASE_W'(half_f(PHASE_W));

    logic signed [PHASE_W:0] saw_diff;
    logic signed [U_W-1:0]   saw_ext;
    logic [PHASE_W-2:0]      tri_f;
    logic signed [U_W-1:0]   tri_u;

    always_comb begin
        saw_diff = $signed({1'b0, phase_i}) - $signed({1'b0, HALF});
        saw_ext  = U_W'(saw_diff);
        // Folding the low bits on the MSB gives a rising then falling ramp.
        tri_f    = phase_i[PHASE_W-1] ? ~phase_i[PHASE_W-2:0] : phase_i[PHASE_W-2:0];
        tri_u    = $signed(U_W'(tri_f) << TRI_SH) - ONE;

        u_o = -ONE;
        case (mode_i)
            MODE_SQUARE: u_o = (phase_i <= HALF) ? ONE : -ONE;
            MODE_PULSE:  u_o = (phase_i < duty_i) ? ONE : -ONE;
            MODE_SAW:    u_o = saw_ext <<< SAW_SH;
            MODE_TRI:    u_o = tri_u;
            default:     u_o = -ONE;
        endcase
    end

endmodule

// File: rtl/multi_wave_gen.sv
// Two-stage waveform shaper: S1 registers shape and wrap flag, S2 registers the
// amplitude-scaled sample. Valid/ready on both sides with full back-pressure.
module multi_wave_gen
    import wave_pkg::*;
#(
    parameter int PHASE_W = 12,
    parameter int FRAC_W  = 16,
    parameter int OUT_W   = 21,
    parameter int AMP_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PHASE_W-1:0] phase,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] duty,
    input  logic [AMP_W-1:0]   amp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   wave,
    output logic               out_wrap
);

    localparam int U_W = FRAC_W + 2;
    localparam int P_W = U_W + AMP_W + 1;
    localparam logic [AMP_W-1:0] AMP_ONE = AMP_W'(1) << (AMP_W - 1);

    // Amplitude is clamped to 1.0, so the shifted product always fits in U_W bits.
    function automatic logic signed [OUT_W-1:0] scale_f(
        input logic signed [U_W-1:0] u,
        input logic [AMP_W-1:0]      a_in
    );
        logic [AMP_W-1:0]      a;
        logic signed [P_W-1:0] prod;
        logic signed [U_W-1:0] sh;
        a    = (a_in > AMP_ONE) ? AMP_ONE : a_in;
        prod = P_W'(u) * P_W'($signed({1'b0, a}));
        sh   = U_W'(prod >>> (AMP_W - 1));
        return OUT_W'(sh);
    endfunction

    logic                  s1_valid_q, s1_valid_d;
    logic signed [U_W-1:0] s1_u_q, s1_u_d;
    logic [AMP_W-1:0]      s1_amp_q, s1_amp_d;
    logic                  s1_wrap_q, s1_wrap_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0]      wave_q, wave_d;
    logic                  wrap_q, wrap_d;
    logic [PHASE_W-1:0]    last_phase_q, last_phase_d;
    logic                  first_q, first_d;
    logic signed [U_W-1:0] shape_u;
    logic                  s2_free;
    logic                  in_fire;

    wave_shape_unit #(
        .PHASE_W (PHASE_W),
        .FRAC_W  (FRAC_W)
    ) u_shape (
        .phase_i (phase),
        .mode_i  (mode),
        .duty_i  (duty),
        .u_o     (shape_u)
    );

    always_comb begin
        s2_free  = !s2_valid_q || out_ready;
        in_ready = rst_n && (!s1_valid_q || s2_free);
        in_fire  = in_valid && in_ready;

        s1_valid_d   = s1_valid_q;
        s1_u_d       = s1_u_q;
        s1_amp_d     = s1_amp_q;
        s1_wrap_d    = s1_wrap_q;
        s2_valid_d   = s2_valid_q;
        wave_d       = wave_q;
        wrap_d       = wrap_q;
        last_phase_d = last_phase_q;
        first_d      = first_q;

        // ---- input -> S1 ----
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_u_d       = shape_u;
            s1_amp_d     = amp;
            s1_wrap_d    = first_q || (phase < last_phase_q);
            last_phase_d = phase;
            first_d      = 1'b0;
        end

        // ---- S1 -> S2 ----
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                wave_d = scale_f(s1_u_q, s1_amp_q);
                wrap_d = s1_wrap_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            wave_q       <= '0;
            wrap_q       <= 1'b0;
            last_phase_q <= '0;
            first_q      <= 1'b1;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            wave_q       <= wave_d;
            wrap_q       <= wrap_d;
            last_phase_q <= last_phase_d;
            first_q      <= first_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_u_q    <= s1_u_d;
        s1_amp_q  <= s1_amp_d;
        s1_wrap_q <= s1_wrap_d;
    end

    assign out_valid = s2_valid_q;
    assign wave      = wave_q;
    assign out_wrap  = wrap_q;

endmodule
